// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM state type, default width and ratio-legality check
package clk_div_pkg;

    localparam int DIV_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, PEND, STOPPING} state_t;

    // A usable ratio must be even and at least 2, so the two phases are equal and non-empty.
    function automatic logic ratio_ok(input logic [31:0] n);
        return !n[0] && (n >= 32'd2);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: half-period counter and toggle register producing the divided clock
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : counter runs and toggles while high, holds while low
//   load       : synchronous counter clear (start of a new run)
//   half       : half period in cycles (ratio with LSB dropped)
//   clk_div    : divided clock, registered
//   rise_pt    : this edge is a low-to-high toggle point
//   fall_pt    : this edge is a high-to-low toggle point
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-2:0] half,
    output logic             clk_div,
    output logic             rise_pt,
    output logic             fall_pt
);

    localparam logic [DIV_W-2:0] ONE = 1;

    logic [DIV_W-2:0] cnt;
    logic             tp;

    assign tp      = cnt == half - ONE;
    assign rise_pt = en & tp & ~clk_div;
    assign fall_pt = en & tp & clk_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_div <= 1'b0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            if (tp) begin
                cnt     <= '0;
                clk_div <= ~clk_div;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free programmable clock divider with a ready/valid config port
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_valid  : configuration request valid
//   cfg_ready  : controller can accept a configuration (IDLE or RUN)
//   cfg_en     : 1 = run at cfg_div, 0 = stop
//   cfg_div    : requested divide ratio (even, >= 2)
//   cfg_err    : one-cycle pulse after a rejected request
//   clk_div    : divided clock, 50% duty
//   div_busy   : a ratio change or stop is pending
//   cur_div    : ratio currently driving clk_div
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int RST_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             div_busy,
    output logic [DIV_W-1:0] cur_div
);

    state_t           state;
    logic [DIV_W-1:0] pend_div;
    logic             xfer;
    logic             ok;
    logic             load;
    logic             rise_pt;
    logic             fall_pt;

    assign xfer = cfg_valid & cfg_ready;
    assign ok   = ratio_ok(32'(cfg_div));
    assign load = (state == IDLE) & xfer & cfg_en & ok;

    clk_div_core #(.DIV_W(DIV_W)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state != IDLE),
        .load    (load),
        .half    (cur_div[DIV_W-1:1]),
        .clk_div (clk_div),
        .rise_pt (rise_pt),
        .fall_pt (fall_pt)
    );

    // Ratio changes take effect only on a rising toggle point and stops only on a
    // falling one, so no phase of clk_div is ever cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_div   <= DIV_W'(RST_DIV);
            pend_div  <= DIV_W'(RST_DIV);
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b0;
            div_busy  <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (xfer && cfg_en) begin
                        if (ok) begin
                            cur_div <= cfg_div;
                            state   <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (!cfg_en) begin
                            state     <= STOPPING;
                            cfg_ready <= 1'b0;
                            div_busy  <= 1'b1;
                        end else if (ok) begin
                            pend_div  <= cfg_div;
                            state     <= PEND;
                            cfg_ready <= 1'b0;
                            div_busy  <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (rise_pt) begin
                        cur_div   <= pend_div;
                        state     <= RUN;
                        cfg_ready <= 1'b1;
                        div_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (fall_pt) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        div_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: randomized and directed checks against a phase-countdown reference model
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_en = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_err;
    logic       clk_div;
    logic       div_busy;
    logic [7:0] cur_div;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: divider described as "cycles left in this phase", with a pending ratio and a stop flag.
    int m_on, m_clk, m_left, m_ratio, m_next, m_pend, m_stop, m_err, m_rdy;

    clk_div_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .clk_div   (clk_div),
        .div_busy  (div_busy),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_clk = 0; m_left = 0; m_ratio = 10; m_next = 0;
        m_pend = 0; m_stop = 0; m_err = 0; m_rdy = 0;
    endtask

    task automatic model_edge(input int v, input int e, input int d);
        int acc, was_on;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc    = (v != 0) && m_rdy != 0 && m_pend == 0 && m_stop == 0;
        was_on = m_on;
        m_err  = 0;
        if (m_on != 0) begin
            if (m_left == 1) begin
                m_clk  = 1 - m_clk;
                m_left = m_ratio / 2;
                if (m_clk == 1 && m_pend != 0) begin
                    m_ratio = m_next;
                    m_left  = m_ratio / 2;
                    m_pend  = 0;
                end
                if (m_clk == 0 && m_stop != 0) begin
                    m_on   = 0;
                    m_stop = 0;
                end
            end else begin
                m_left--;
            end
        end
        if (acc != 0) begin
            if (e == 0) begin
                if (was_on != 0) m_stop = 1;
            end else if (d % 2 != 0 || d < 2) begin
                m_err = 1;
            end else if (was_on != 0) begin
                m_pend = 1;
                m_next = d;
            end else begin
                m_on = 1; m_ratio = d; m_left = d / 2; m_clk = 0;
            end
        end
        m_rdy = 1;
    endtask

    task automatic compare_all();
        chk("clk_div", clk_div, m_clk);
        chk("cfg_ready", cfg_ready, (m_rdy != 0 && m_pend == 0 && m_stop == 0) ? 1 : 0);
        chk("div_busy", div_busy, (m_pend != 0 || m_stop != 0) ? 1 : 0);
        chk("cur_div", cur_div, m_ratio);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic cyc(input logic v, input logic e, input logic [7:0] d);
        cfg_valid = v;
        cfg_en    = e;
        cfg_div   = d;
        @(posedge clk);
        model_edge(int'(v), int'(e), int'(d));
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 8'($urandom));
    endtask

    task automatic wait_level(input logic lvl);
        for (int i = 0; i < 400; i++) begin
            if (clk_div == lvl) return;
            idle(1);
        end
        n_chk++;
        n_bad++;
        $display("FAIL wait_clk_div: got %0d, expected %0d within 400 cycles", clk_div, lvl);
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_clk_div", clk_div, 0);
        chk("rst_cur_div", cur_div, 10);
        chk("rst_busy", div_busy, 0);
        chk("rst_ready", cfg_ready, 0);
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        idle(2);
        compare_all();
        rst_n = 1'b1;
        idle(20);

        cyc(1'b1, 1'b1, 8'd4);
        idle(12);

        cyc(1'b1, 1'b1, 8'd10);
        idle(30);
        wait_level(1'b0);
        wait_level(1'b1);
        idle(2);
        cyc(1'b1, 1'b1, 8'd4);
        idle(30);

        cyc(1'b1, 1'b1, 8'd7);
        idle(3);
        cyc(1'b1, 1'b1, 8'd0);
        idle(10);

        cyc(1'b1, 1'b1, 8'd6);
        idle(20);
        wait_level(1'b0);
        wait_level(1'b1);
        idle(1);
        cyc(1'b1, 1'b0, 8'd0);
        idle(15);

        cyc(1'b1, 1'b1, 8'd10);
        idle(12);
        cyc(1'b1, 1'b1, 8'd4);
        idle(2);
        pulse_reset();
        idle(10);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                pulse_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                logic [7:0] d;
                case ($urandom_range(0, 3))
                    0: d = 8'($urandom_range(0, 255));
                    1: d = 8'($urandom_range(0, 3));
                    default: d = 8'(2 * $urandom_range(1, 10));
                endcase
                cyc(1'b1, $urandom_range(0, 3) != 0, d);
            end else begin
                idle(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
        $finish;
    end

endmodule
